// File: rtl/atri_timebase_pkg.sv
// Shared definitions for the IRS timebase: FSM state encoding and the
// widths of the exported period and PPS-count values.
package atri_timebase_pkg;

    localparam int PERIOD_W  = 32;
    localparam int PPS_CNT_W = 16;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        NO_PPS  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_e;

endpackage

// File: rtl/atri_pps_sync.sv
// PPS input conditioning: two-flop synchroniser followed by a registered
// rising-edge detector.
//   clk_i      : IRS system clock
//   rst_i      : synchronous active-high reset
//   pps_i      : asynchronous PPS input
//   pps_flag_o : one-cycle pulse per PPS rising edge, asserted on the 3rd
//                clk_i edge after pps_i is first sampled high
module atri_pps_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pps_i,
    output logic pps_flag_o
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            prev       <= 1'b0;
            pps_flag_o <= 1'b0;
        end else begin
            meta       <= pps_i;
            sync       <= meta;
            prev       <= sync;
            pps_flag_o <= sync & ~prev;
        end
    end

endmodule

// File: rtl/atri_irs_timebase.sv
// IRS timebase: qualifies the buffered system clock against the station PPS
// and generates a periodic sync strobe for the sampling/readout logic.
//   clk_i / rst_i    : system clock, synchronous active-high reset
//   pps_i            : asynchronous PPS input
//   resync_en_i      : lets PPS edges realign the sync strobe while locked
//   pps_flag_o       : pulse per detected PPS rising edge
//   period_o         : last measured PPS period (cycles)
//   period_valid_o   : pulse when period_o updates
//   period_err_o     : pulse when a measured period is outside the window
//   locked_o/lost_o  : decoded from the FSM state
//   state_o          : FSM state (0 NO_PPS, 1 ACQUIRE, 2 LOCKED, 3 LOST)
//   pps_count_o      : PPS edges since reset, wrapping
//   sync_o           : one-cycle sync strobe every SYNC_DIV cycles
// Handshake: all pulse outputs are single-cycle qualifiers with no
// back-pressure; a consumer must sample them on the cycle they are high.
module atri_irs_timebase
    import atri_timebase_pkg::*;
#(
    parameter int unsigned NOMINAL_HZ = 100000000,
    parameter int unsigned TOLERANCE  = 1000,
    parameter int unsigned SYNC_DIV   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pps_i,
    input  logic                 resync_en_i,
    output logic                 pps_flag_o,
    output logic [PERIOD_W-1:0]  period_o,
    output logic                 period_valid_o,
    output logic                 period_err_o,
    output logic                 locked_o,
    output logic                 lost_o,
    output logic [1:0]           state_o,
    output logic [PPS_CNT_W-1:0] pps_count_o,
    output logic                 sync_o
);

    localparam logic [PERIOD_W-1:0] PCNT_MAX     = '1;
    localparam logic [PERIOD_W-1:0] TIMEOUT_CYC  = PERIOD_W'(NOMINAL_HZ + NOMINAL_HZ / 2);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] WIN_LO       = (NOMINAL_HZ > TOLERANCE) ?
                                                   PERIOD_W'(NOMINAL_HZ - TOLERANCE) : '0;
    localparam logic [PERIOD_W-1:0] WIN_HI       = PERIOD_W'(NOMINAL_HZ + TOLERANCE);
    localparam int                  SYNC_W       = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;
    localparam logic [SYNC_W-1:0]   SYNC_LAST    = SYNC_W'(SYNC_DIV - 1);

    logic                pps_flag;
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] measured;
    logic                in_window;
    logic                timeout;
    state_e              state;
    state_e              state_next;
    logic                load_period;
    logic                flag_err;
    logic [SYNC_W-1:0]   sync_cnt;
    logic                resync;

    atri_pps_sync u_pps_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pps_i      (pps_i),
        .pps_flag_o (pps_flag)
    );

    assign pps_flag_o = pps_flag;

    // pcnt holds (cycles since last edge) - 1, so the edge itself adds one.
    always_ff @(posedge clk_i) begin
        if (rst_i || pps_flag) begin
            pcnt <= '0;
        end else if (pcnt != PCNT_MAX) begin
            pcnt <= pcnt + PERIOD_W'(1);
        end
    end

    assign measured  = (pcnt == PCNT_MAX) ? pcnt : pcnt + PERIOD_W'(1);
    assign in_window = (measured >= WIN_LO) && (measured <= WIN_HI);
    assign timeout   = (pcnt == TIMEOUT_LAST);

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= NO_PPS;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. An edge always takes priority over a timeout.
    always_comb begin
        state_next  = state;
        load_period = 1'b0;
        flag_err    = 1'b0;
        case (state)
            NO_PPS: begin
                if (pps_flag) state_next = ACQUIRE;
            end
            ACQUIRE: begin
                if (pps_flag) begin
                    load_period = 1'b1;
                    if (in_window) state_next = LOCKED;
                    else           flag_err   = 1'b1;
                end else if (timeout) begin
                    state_next = LOST;
                end
            end
            LOCKED: begin
                if (pps_flag) begin
                    load_period = 1'b1;
                    if (!in_window) begin
                        flag_err   = 1'b1;
                        state_next = ACQUIRE;
                    end
                end else if (timeout) begin
                    state_next = LOST;
                end
            end
            LOST: begin
                // pcnt is stale here, so the edge only restarts acquisition.
                if (pps_flag) state_next = ACQUIRE;
            end
            default: state_next = NO_PPS;
        endcase
    end

    // FSM: outputs decoded from the registered state
    always_comb begin
        locked_o = (state == LOCKED);
        lost_o   = (state == LOST);
        state_o  = state;
    end

    // Period report lands on the same edge as the state update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_o       <= '0;
            period_valid_o <= 1'b0;
            period_err_o   <= 1'b0;
        end else begin
            period_valid_o <= load_period;
            period_err_o   <= flag_err;
            if (load_period) period_o <= measured;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pps_count_o <= '0;
        end else if (pps_flag) begin
            pps_count_o <= pps_count_o + PPS_CNT_W'(1);
        end
    end

    // Sync generator free-runs from reset; a locked edge restarts its phase.
    assign resync = pps_flag & locked_o & resync_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_cnt <= '0;
            sync_o   <= 1'b0;
        end else begin
            sync_o <= (sync_cnt == SYNC_LAST) | resync;
            if (resync || sync_cnt == SYNC_LAST) begin
                sync_cnt <= '0;
            end else begin
                sync_cnt <= sync_cnt + SYNC_W'(1);
            end
        end
    end

endmodule

// File: doc/atri_irs_timebase.md
Name: atri_irs_timebase

Overview:
- Timing stage directly downstream of the differential reference-clock buffer; runs entirely on the buffered IRS system clock.
- Qualifies that clock against the station PPS: synchronises PPS, measures cycles per PPS period, and declares lock or loss.
- Produces a PPS-aligned periodic sync strobe for the IRS sampling/readout logic.
- Exports PPS count and measured period for the register bank.

Parameters:
- NOMINAL_HZ, 100000000, expected irs_sys_clk cycles per PPS period.
- TOLERANCE, 1000, allowed absolute deviation, in cycles, from NOMINAL_HZ.
- SYNC_DIV, 8, sync strobe period in cycles; must be ≥2.

Ports:
- clk_i  in  1  IRS system clock (buffered, 0° phase).
- rst_i  in  1  synchronous, active-high reset.
- pps_i  in  1  asynchronous PPS input.
- resync_en_i  in  1  allows PPS edges to realign the sync strobe while locked.
- pps_flag_o  out  1  one-cycle pulse per detected PPS rising edge.
- period_o  out  32  last measured PPS period in cycles.
- period_valid_o  out  1  one-cycle pulse when period_o updates.
- period_err_o  out  1  one-cycle pulse when a measured period is out of window.
- locked_o  out  1  high in LOCKED.
- lost_o  out  1  high in LOST.
- state_o  out  2  encoded FSM state.
- pps_count_o  out  16  PPS edges since reset; wraps 0xFFFF→0.
- sync_o  out  1  periodic one-cycle sync strobe.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk_i. Reset is synchronous, active-high (rst_i).
  - All outputs are 0 at reset. State = NO_PPS. Sync counter = 0. Period counter = 0. Synchroniser flops = 0.
- PPS path:
  - pps_i → two-flop synchroniser → registered rising-edge detect. This gives pps_flag_o.
  - Latency: pps_flag_o asserts on the 3rd clk_i edge after pps_i is first sampled high.
  - One pulse per edge. A level held high produces no further pulses.
- Period counter (pcnt, 32-bit):
  - Loads 0 on a pps_flag cycle; otherwise increments, saturating at 0xFFFFFFFF.
  - On an edge, the measured period = pcnt+1. For edges at cycles t and t+N, the measured value is N.
- Window:
  - In-window means NOMINAL_HZ−TOLERANCE ≤ period ≤ NOMINAL_HZ+TOLERANCE, inclusive.
  - Timeout constant TIMEOUT_CYC = NOMINAL_HZ + NOMINAL_HZ/2.
- FSM encoding: NO_PPS=0, ACQUIRE=1, LOCKED=2, LOST=3.
  - NO_PPS: edge → ACQUIRE. No period reported, since it is the first edge.
  - ACQUIRE:
    - edge → latch period_o and pulse period_valid_o.
    - If in-window → LOCKED.
    - Otherwise pulse period_err_o and stay in ACQUIRE.
  - LOCKED:
    - edge → latch period_o and pulse period_valid_o.
    - If in-window, stay in LOCKED.
    - Otherwise pulse period_err_o and go to ACQUIRE.
  - ACQUIRE or LOCKED: pcnt == TIMEOUT_CYC−1 with no edge → LOST.
  - LOST: edge → ACQUIRE. The period is not reported, because pcnt is stale.
  - An edge in the same cycle as timeout: the edge wins and no LOST is entered.
- Output timing:
  - period_o, period_valid_o, period_err_o and state_o update on the cycle after pps_flag_o.
  - locked_o and lost_o are decoded from the registered state.
- pps_count_o increments on every pps_flag_o, in any state.
- Sync strobe:
  - sync_cnt runs 0..SYNC_DIV−1 and wraps.
  - Registered: sync_o <= (sync_cnt==SYNC_DIV−1) | resync.
  - resync = pps_flag & locked_o & resync_en_i. On resync, sync_cnt loads 0; otherwise it increments.
  - Result: the first sync_o comes 1 cycle after the resync cycle, then repeats every SYNC_DIV cycles.
  - A resync coinciding with a natural wrap yields a single pulse.
  - Sync free-runs from reset regardless of PPS state.
- Reset mid-operation: all state, counts and strobes clear the next cycle. No pulse is emitted during reset.

Decomposition:
- Shared package atri_timebase_pkg holds:
  - FSM state encodings (NO_PPS, ACQUIRE, LOCKED, LOST);
  - the period width constant (32);
  - the pps-count width constant (16).
- One sub-module is natural: atri_pps_sync (2-flop synchroniser plus edge detect, output pps_flag).
- The counters, FSM and sync generator stay in the top module.

Test Plan (bench params: NOMINAL_HZ=1000, TOLERANCE=10, SYNC_DIV=8, so TIMEOUT_CYC=1500):
- Reset release, no PPS for 1600 cycles → state_o=0; locked_o=0, lost_o=0; sync_o pulses every 8 cycles, first pulse 8 cycles after reset release; pps_count_o=0.
- PPS edges every 1000 cycles ×3 → after the 2nd edge: period_o=1000, period_valid_o one pulse, state_o=2, locked_o=1; pps_count_o=3 after the 3rd edge; pps_flag_o pulses exactly 3 cycles after each pps_i rise.
- While locked, next edge after 1011 cycles → period_err_o pulse, period_o=1011, state_o=1. A following edge at 990 → LOCKED (boundary inclusive).
- While locked, stop PPS → lost_o=1 on the cycle after pcnt reaches 1499. Next edge → state_o=1 with no period_valid_o. The edge after that, 1000 cycles later → LOCKED.
- Locked, resync_en_i=1, PPS edge when sync_cnt=3 → sync_o one cycle after pps_flag_o, then every 8 cycles. With resync_en_i=0 the phase is unchanged.
- rst_i asserted 1 cycle mid-LOCKED → next cycle all outputs 0 and state_o=0. An edge during reset is ignored. Drive 70000 edges → pps_count_o wraps to 70000 mod 65536 = 4464.
